multi_host_reg_bank: RTL and testbench
======================================

# multi_host_reg_bank

Shared configuration/status register bank serving NUM_HOSTS independent host interfaces (SPI, I2C, future debug ports) through a round-robin arbiter with a req/ack handshake. Replaces the fixed single-host mux in front of the register bank: every host can access the bank, accesses are serialised, and each access returns read data and an error flag. Sits between the serial peripherals and the design's config/status vectors.

## Interface
Parameters:
- NUM_HOSTS, 2, number of host ports (1..8)
- REG_W, 8, register and data width
- ADDR_W, 8, host address width; must be ≥ $clog2(NUM_CFG+NUM_STATUS)
- NUM_CFG, 8, read/write config registers at addresses 0..NUM_CFG-1
- NUM_STATUS, 8, read-only status registers at addresses NUM_CFG..NUM_CFG+NUM_STATUS-1
- CFG_RESET, '0, NUM_CFG*REG_W reset image of config_regs

Ports (clock is `clk`, reset is `rstb`: one clock; reset asynchronous, active-low):
- clk  in  1  system clock
- rstb  in  1  asynchronous active-low reset
- ena  in  1  block enable; low blocks new grants
- host_req  in  NUM_HOSTS  per-host access request, level
- host_wr_rdn  in  NUM_HOSTS  per-host 1 = write, 0 = read
- host_addr  in  NUM_HOSTS*ADDR_W  per-host address, host i at [i*ADDR_W +: ADDR_W]
- host_wdata  in  NUM_HOSTS*REG_W  per-host write data
- host_ack  out  NUM_HOSTS  one-cycle completion pulse, one-hot
- host_err  out  NUM_HOSTS  error flag, valid with host_ack
- host_rdata  out  REG_W  shared read data, valid with any host_ack
- grant  out  NUM_HOSTS  one-hot current owner, 0 when idle
- config_regs  out  NUM_CFG*REG_W  config register contents
- status_regs  in  NUM_STATUS*REG_W  status register sources

## Operation
- FSM states IDLE, ACCESS, ACK. Reset → IDLE.
- IDLE: if ena=1 and any host_req bit set, pick winner by round robin, register grant, latch winner's wr_rdn/addr/wdata → ACCESS. Else stay.
- Round robin: search starts at rr_ptr, ascending with wrap; after each grant rr_ptr = winner+1 mod NUM_HOSTS. rr_ptr reset 0.
- ACCESS: decode latched address (full ADDR_W compare, no truncation/aliasing):
  - config, write: register updated at end of ACCESS; err=0.
  - config, read: rdata = register; err=0.
  - status, read: rdata = status_regs sampled in ACCESS; err=0.
  - status, write: no effect; rdata=0; err=1.
  - addr ≥ NUM_CFG+NUM_STATUS: no effect; rdata=0; err=1.
  - → ACK.
- ACK: host_ack[winner]=1, host_err[winner], host_rdata driven from registers; grant cleared at exit → IDLE.
- Host rule: deassert req on the edge where it samples ack=1; req still high in the following IDLE cycle is a new access.
- Req drop before ack: access still completes, ack still issued.
- ena low in ACCESS/ACK: in-flight access completes; only IDLE grants gated.
- Reset mid-access: everything returns to reset values, no ack, partial write discarded.

## Timing
- Req seen high in IDLE cycle N → grant valid N+1 (ACCESS) → ack/err/rdata valid N+2 → IDLE at N+3. Write visible on config_regs from N+2.
- Max throughput one access per 3 cycles; back-to-back competing hosts alternate.
- Reset values: host_ack=0, host_err=0, host_rdata=0, grant=0, config_regs=CFG_RESET, state IDLE.
- host_rdata and host_err held between acks (do not toggle outside ACK update).

## Structure
- Package reg_bank_pkg: state enum (IDLE, ACCESS, ACK), address-class enum (CFG, STATUS, INVALID), helper function for address decode.
- Sub-module rr_arbiter #(N): req vector + ptr in, one-hot grant + index out, combinational; FSM and storage in the top.

## Test plan
- Reset: config_regs = CFG_RESET, all outputs 0; host0 read addr 0 → ack at +2 cycles, rdata=CFG_RESET byte 0, err=0.
- Host1 writes 0xA5 to addr 3, then host0 reads addr 3 → rdata 0xA5, err=0; config_regs[31:24]=0xA5.
- status_regs[7:0]=0x3C; read addr NUM_CFG → 0x3C; write addr NUM_CFG → err=1, status unaffected, no config change.
- Read addr 16 and 0xFF (defaults) → err=1, rdata=0, no register changed.
- Both hosts request continuously from reset: grants alternate 0,1,0,1; each ack one-hot, spaced 3 cycles.
- ena=0 with req held: no grant; ena rises → grant next cycle; assert rstb=0 during ACCESS of a write → no ack, register keeps reset value.

Source files
------------

// File: rtl/multi_host_reg_bank_pkg.sv
// Shared types and address decode for the multi-host register bank.
package reg_bank_pkg;

    // Access sequencing: pick owner, perform access, report completion.
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_e;

    // What a host address refers to.
    typedef enum logic [1:0] {
        CFG,
        STATUS,
        INVALID
    } addr_class_e;

    // Classify a full-width address. The address is widened rather than
    // truncated, so out-of-range values never alias onto real registers.
    function automatic addr_class_e decode_addr(input logic [31:0] addr,
                                                input int num_cfg,
                                                input int num_status);
        if (addr < 32'(num_cfg))
            return CFG;
        else if (addr < 32'(num_cfg + num_status))
            return STATUS;
        else
            return INVALID;
    endfunction

endpackage

// File: rtl/multi_host_reg_bank_rr_arbiter.sv
// Combinational round-robin arbiter: the search begins at ptr_i and walks
// upward with wrap-around; the first requester found wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    logic found;
    int   j;

    // Rotating priority search starting at the pointer.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/multi_host_reg_bank.sv
// Shared config/status register bank reached by several independent hosts.
// One access at a time: IDLE picks an owner, ACCESS performs the access,
// and ACK returns a one-cycle completion pulse to that owner.
module multi_host_reg_bank
    import reg_bank_pkg::*;
#(
    parameter int NUM_HOSTS  = 2,
    parameter int REG_W      = 8,
    parameter int ADDR_W     = 8,
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter logic [NUM_CFG*REG_W-1:0] CFG_RESET = '0
) (
    input  logic                           clk,
    input  logic                           rstb,
    input  logic                           ena,
    input  logic [NUM_HOSTS-1:0]           host_req,
    input  logic [NUM_HOSTS-1:0]           host_wr_rdn,
    input  logic [NUM_HOSTS*ADDR_W-1:0]    host_addr,
    input  logic [NUM_HOSTS*REG_W-1:0]     host_wdata,
    output logic [NUM_HOSTS-1:0]           host_ack,
    output logic [NUM_HOSTS-1:0]           host_err,
    output logic [REG_W-1:0]               host_rdata,
    output logic [NUM_HOSTS-1:0]           grant,
    output logic [NUM_CFG*REG_W-1:0]       config_regs,
    input  logic [NUM_STATUS*REG_W-1:0]    status_regs
);

    localparam int IW = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;

    state_e                          state_q, state_d;
    logic [NUM_HOSTS-1:0]            grant_q, grant_d;
    logic [IW-1:0]                   ptr_q, ptr_d;
    logic                            wr_q, wr_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [REG_W-1:0]                wdata_q, wdata_d;
    logic [REG_W-1:0]                rdata_q, rdata_d;
    logic [NUM_HOSTS-1:0]            herr_q, herr_d;
    logic [NUM_CFG-1:0][REG_W-1:0]   cfg_q, cfg_d;

    logic [NUM_STATUS-1:0][REG_W-1:0] stat;
    logic [NUM_HOSTS-1:0]            arb_grant;
    logic [IW-1:0]                   arb_idx;
    logic                            start;
    logic [31:0]                     addr32;
    addr_class_e                     cls;
    logic [REG_W-1:0]                acc_rdata;
    logic                            acc_err;

    assign stat   = status_regs;
    assign addr32 = 32'(addr_q);
    assign start  = (state_q == IDLE) && ena && (|host_req);

    rr_arbiter #(
        .N  (NUM_HOSTS),
        .IW (IW)
    ) u_arb (
        .req_i   (host_req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: ena only gates leaving IDLE; in-flight accesses always finish.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCESS;
            ACCESS:  state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Completion pulse goes only to the current owner.
    always_comb begin
        host_ack = '0;
        if (state_q == ACK) host_ack = grant_q;
    end

    // Decode and perform the latched access; config writes only commit in ACCESS.
    always_comb begin
        cls       = decode_addr(addr32, NUM_CFG, NUM_STATUS);
        acc_rdata = '0;
        acc_err   = 1'b0;
        cfg_d     = cfg_q;
        case (cls)
            CFG: begin
                for (int i = 0; i < NUM_CFG; i++) begin
                    if (addr32 == 32'(i)) begin
                        acc_rdata = cfg_q[i];
                        if (wr_q && state_q == ACCESS) cfg_d[i] = wdata_q;
                    end
                end
            end
            STATUS: begin
                if (wr_q) begin
                    acc_err = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_STATUS; i++) begin
                        if (addr32 == 32'(NUM_CFG + i)) acc_rdata = stat[i];
                    end
                end
            end
            default: acc_err = 1'b1;
        endcase
    end

    // Datapath next-state: latch the winner's request, capture results, release grant.
    always_comb begin
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        herr_d  = herr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    grant_d = arb_grant;
                    ptr_d   = (arb_idx == IW'(NUM_HOSTS - 1)) ? '0 : arb_idx + IW'(1);
                    for (int i = 0; i < NUM_HOSTS; i++) begin
                        if (arb_grant[i]) begin
                            wr_d    = host_wr_rdn[i];
                            addr_d  = host_addr[i*ADDR_W +: ADDR_W];
                            wdata_d = host_wdata[i*REG_W +: REG_W];
                        end
                    end
                end
            end
            ACCESS: begin
                rdata_d = acc_rdata;
                herr_d  = acc_err ? grant_q : '0;
            end
            ACK:     grant_d = '0;
            default: grant_d = '0;
        endcase
    end

    // Datapath and register storage.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            grant_q <= '0;
            ptr_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            herr_q  <= '0;
            cfg_q   <= CFG_RESET;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            herr_q  <= herr_d;
            cfg_q   <= cfg_d;
        end
    end

    assign grant       = grant_q;
    assign host_err    = herr_q;
    assign host_rdata  = rdata_q;
    assign config_regs = cfg_q;

endmodule

// File: tb/tb_multi_host_reg_bank.sv
// Directed bench for multi_host_reg_bank (2 hosts, 8 config + 8 status regs).
module tb_multi_host_reg_bank;

    localparam logic [63:0] CFG_RST = 64'h8877_6655_4433_2211;
    localparam logic [63:0] STAT_V  = 64'hF0E1_D2C3_B4A5_963C;

    logic        clk;
    logic        rstb;
    logic        ena;
    logic [1:0]  host_req;
    logic [1:0]  host_wr_rdn;
    logic [15:0] host_addr;
    logic [15:0] host_wdata;
    logic [1:0]  host_ack;
    logic [1:0]  host_err;
    logic [7:0]  host_rdata;
    logic [1:0]  grant;
    logic [63:0] config_regs;
    logic [63:0] status_regs;

    int n_cmp;
    int n_bad;

    multi_host_reg_bank #(
        .NUM_HOSTS  (2),
        .REG_W      (8),
        .ADDR_W     (8),
        .NUM_CFG    (8),
        .NUM_STATUS (8),
        .CFG_RESET  (CFG_RST)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .host_req    (host_req),
        .host_wr_rdn (host_wr_rdn),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_err    (host_err),
        .host_rdata  (host_rdata),
        .grant       (grant),
        .config_regs (config_regs),
        .status_regs (status_regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One host access; returns what was observed, waits at most 10 cycles.
    task automatic do_access(input int h, input logic wr, input logic [7:0] a,
                             input logic [7:0] wd, output logic [7:0] rd,
                             output logic [1:0] ackv, output logic [1:0] errv,
                             output logic [1:0] gnt, output int lat);
        @(negedge clk);
        host_req[h]          = 1'b1;
        host_wr_rdn[h]       = wr;
        host_addr[h*8 +: 8]  = a;
        host_wdata[h*8 +: 8] = wd;
        lat  = 0;
        ackv = '0;
        gnt  = '0;
        while (ackv == 2'b00 && lat < 10) begin
            @(negedge clk);
            lat++;
            if (lat == 1) gnt = grant;
            ackv = host_ack;
        end
        rd          = host_rdata;
        errv        = host_err;
        host_req[h] = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rd; logic [1:0] ackv, errv, gnt; int lat;
        repeat (2) @(negedge clk);
        n_cmp++; if (config_regs !== CFG_RST) begin n_bad++; $display("FAIL reset_cfg: got %h want %h", config_regs, CFG_RST); end
        n_cmp++; if ({host_ack, host_err, grant, host_rdata} !== 14'h0) begin n_bad++;
            $display("FAIL reset_outs: ack %b err %b grant %b rdata %h want all 0", host_ack, host_err, grant, host_rdata); end
        rstb = 1'b1;
        do_access(0, 1'b0, 8'd0, 8'h00, rd, ackv, errv, gnt, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL first_latency: got %0d want 2", lat); end
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL first_grant: got %b want 01", gnt); end
        n_cmp++; if (ackv !== 2'b01) begin n_bad++; $display("FAIL first_ack: got %b want 01", ackv); end
        n_cmp++; if (rd !== 8'h11 || errv !== 2'b00) begin n_bad++; $display("FAIL first_read: rdata %h err %b want 11 00", rd, errv); end
    endtask

    task automatic test_write_read();
        logic [7:0] rd; logic [1:0] ackv, errv, gnt; int lat;
        do_access(1, 1'b1, 8'd3, 8'hA5, rd, ackv, errv, gnt, lat);
        n_cmp++; if (ackv !== 2'b10 || errv !== 2'b00) begin n_bad++; $display("FAIL wr_ack: ack %b err %b want 10 00", ackv, errv); end
        n_cmp++; if (config_regs[31:24] !== 8'hA5) begin n_bad++; $display("FAIL wr_cfg3: got %h want a5", config_regs[31:24]); end
        do_access(0, 1'b0, 8'd3, 8'h00, rd, ackv, errv, gnt, lat);
        n_cmp++; if (rd !== 8'hA5 || errv !== 2'b00 || ackv !== 2'b01) begin n_bad++;
            $display("FAIL rd_back: rdata %h err %b ack %b want a5 00 01", rd, errv, ackv); end
        repeat (3) @(negedge clk);
        n_cmp++; if (host_rdata !== 8'hA5 || host_ack !== 2'b00) begin n_bad++;
            $display("FAIL rdata_hold: rdata %h ack %b want a5 00", host_rdata, host_ack); end
    endtask

    task automatic test_status();
        logic [7:0] rd; logic [1:0] ackv, errv, gnt; int lat;
        do_access(0, 1'b0, 8'd8, 8'h00, rd, ackv, errv, gnt, lat);
        n_cmp++; if (rd !== 8'h3C || errv !== 2'b00) begin n_bad++; $display("FAIL stat_rd: rdata %h err %b want 3c 00", rd, errv); end
        do_access(1, 1'b0, 8'd15, 8'h00, rd, ackv, errv, gnt, lat);
        n_cmp++; if (rd !== 8'hF0 || errv !== 2'b00) begin n_bad++; $display("FAIL stat_rd_top: rdata %h err %b want f0 00", rd, errv); end
        do_access(1, 1'b1, 8'd8, 8'h77, rd, ackv, errv, gnt, lat);
        n_cmp++; if (rd !== 8'h00 || errv !== 2'b10 || ackv !== 2'b10) begin n_bad++;
            $display("FAIL stat_wr: rdata %h err %b ack %b want 00 10 10", rd, errv, ackv); end
        n_cmp++; if (config_regs !== 64'h8877_6655_A533_2211) begin n_bad++; $display("FAIL stat_wr_cfg: got %h want 88776655a5332211", config_regs); end
    endtask

    task automatic test_invalid();
        logic [7:0] rd; logic [1:0] ackv, errv, gnt; int lat;
        do_access(0, 1'b0, 8'd16, 8'h00, rd, ackv, errv, gnt, lat);
        n_cmp++; if (rd !== 8'h00 || errv !== 2'b01) begin n_bad++; $display("FAIL inv16: rdata %h err %b want 00 01", rd, errv); end
        do_access(0, 1'b1, 8'hFF, 8'h99, rd, ackv, errv, gnt, lat);
        n_cmp++; if (rd !== 8'h00 || errv !== 2'b01) begin n_bad++; $display("FAIL invff: rdata %h err %b want 00 01", rd, errv); end
        n_cmp++; if (config_regs !== 64'h8877_6655_A533_2211) begin n_bad++; $display("FAIL inv_cfg: got %h want 88776655a5332211", config_regs); end
        do_access(1, 1'b0, 8'd1, 8'h00, rd, ackv, errv, gnt, lat);
        n_cmp++; if (rd !== 8'h22 || errv !== 2'b00) begin n_bad++; $display("FAIL err_clear: rdata %h err %b want 22 00", rd, errv); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] av [4];
        logic [7:0] dv [4];
        int         cv [4];
        int         na;
        logic [1:0] exp_a [4];
        logic [7:0] exp_d [4];
        exp_a[0] = 2'b01; exp_a[1] = 2'b10; exp_a[2] = 2'b01; exp_a[3] = 2'b10;
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h11; exp_d[3] = 8'h22;
        na = 0;
        @(negedge clk);
        rstb = 1'b0;
        host_wr_rdn = 2'b00;
        host_addr   = {8'd1, 8'd0};
        host_req    = 2'b11;
        @(negedge clk);
        rstb = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (host_ack != 2'b00 && na < 4) begin
                av[na] = host_ack; dv[na] = host_rdata; cv[na] = c; na++;
            end
        end
        host_req = 2'b00;
        repeat (4) @(negedge clk);
        n_cmp++; if (na !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d want 4", na); end
        for (int k = 0; k < na; k++) begin
            n_cmp++; if (av[k] !== exp_a[k] || dv[k] !== exp_d[k] || cv[k] !== 2 + 3*k) begin n_bad++;
                $display("FAIL b2b_ack%0d: ack %b rdata %h cycle %0d want %b %h %0d", k, av[k], dv[k], cv[k], exp_a[k], exp_d[k], 2 + 3*k); end
        end
    endtask

    task automatic test_ena();
        int bad_cnt;
        bad_cnt = 0;
        @(negedge clk);
        ena = 1'b0;
        host_wr_rdn[0]  = 1'b0;
        host_addr[7:0]  = 8'd2;
        host_req[0]     = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (grant != 2'b00 || host_ack != 2'b00) bad_cnt++;
        end
        n_cmp++; if (bad_cnt !== 0) begin n_bad++; $display("FAIL ena_block: got %0d active cycles want 0", bad_cnt); end
        ena = 1'b1;
        @(negedge clk);
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL ena_grant: got %b want 01", grant); end
        ena = 1'b0;
        @(negedge clk);
        n_cmp++; if (host_ack !== 2'b01 || host_rdata !== 8'h33) begin n_bad++;
            $display("FAIL ena_inflight: ack %b rdata %h want 01 33", host_ack, host_rdata); end
        host_req[0] = 1'b0;
        ena = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bad_cnt;
        bad_cnt = 0;
        @(negedge clk);
        host_wr_rdn[1]      = 1'b1;
        host_addr[15:8]     = 8'd5;
        host_wdata[15:8]    = 8'h5A;
        host_req[1]         = 1'b1;
        @(negedge clk);
        n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL mid_grant: got %b want 10", grant); end
        rstb = 1'b0;
        #1;
        n_cmp++; if (grant !== 2'b00 || host_ack !== 2'b00) begin n_bad++; $display("FAIL mid_clear: grant %b ack %b want 00 00", grant, host_ack); end
        host_req[1] = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (host_ack != 2'b00) bad_cnt++;
        end
        n_cmp++; if (bad_cnt !== 0) begin n_bad++; $display("FAIL mid_noack: got %0d acks want 0", bad_cnt); end
        n_cmp++; if (config_regs !== CFG_RST) begin n_bad++; $display("FAIL mid_cfg: got %h want %h", config_regs, CFG_RST); end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rstb        = 1'b0;
        ena         = 1'b1;
        host_req    = '0;
        host_wr_rdn = '0;
        host_addr   = '0;
        host_wdata  = '0;
        status_regs = STAT_V;
        test_reset();
        test_write_read();
        test_status();
        test_invalid();
        test_back_to_back();
        test_ena();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
